mem_port_arbiter: RTL and testbench

Two-port front end that shares the single byte-lane RAM manager between the instruction-fetch port (I) and the load/store port (D). It arbitrates requests and generates per-lane write enables from the access size. It sequences the RAM read latency and formats load data (byte/half/word, sign or zero extension) before returning it to the requester. It sits between the core's fetch/memory stages and the RAM manager.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter_formatter.sv | 21 ++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM front end: size codes, port ids,
// arbiter state encoding and the store lane-enable helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } stateT;

  // Size code 11 behaves as a word access.
  function automatic logic [3:0] laneMask(input logic [1:0] size);
    case (size)
      SZ_BYTE: laneMask = 4'b0001;
      SZ_HALF: laneMask = 4'b0011;
      SZ_WORD: laneMask = 4'b1111;
      default: laneMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, load/store port and RAM manager signals.
// slave = the arbiter; master = the core stages and RAM manager around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_signed;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_dout,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_din
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter_formatter.sv
// Load data formatting: extracts byte/half/word from the raw RAM word and
// applies sign or zero extension.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{isSigned & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{isSigned & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the RAM manager between fetch (I) and
// load/store (D), sequencing read latency and returning formatted data.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  stateT             state, stateNext;
  logic [2:0]        cnt, cntNext;
  logic              lg;
  logic              ownReg;
  logic [1:0]        sizeReg;
  logic              signedReg;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       iRdataReg, dRdataReg;
  logic              lastCycle, canGrant, iGnt, dGnt, readGnt, storeGnt;
  logic [31:0]       fmtData;

  load_formatter fmt (
    .raw      (bus.mem_dout),
    .size     (sizeReg),
    .isSigned (signedReg),
    .data     (fmtData)
  );

  // Grants open in IDLE and on the response cycle of a read, so reads stream back to back.
  always_comb begin
    lastCycle = (state == ST_WAIT) && (cnt == 3'd0);
    canGrant  = rst_n && ((state == ST_IDLE) || lastCycle);
    iGnt      = 1'b0;
    dGnt      = 1'b0;
    if (canGrant) begin
      if (bus.i_req && bus.d_req) begin
        if (lg == PORT_I) dGnt = 1'b1;
        else              iGnt = 1'b1;
      end else begin
        iGnt = bus.i_req;
        dGnt = bus.d_req;
      end
    end
    storeGnt = dGnt && bus.d_we;
    readGnt  = iGnt || (dGnt && !bus.d_we);
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (readGnt) begin
      stateNext = ST_WAIT;
      cntNext   = CNT_INIT;
    end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
      cntNext = cnt - 3'd1;
    end else begin
      stateNext = ST_IDLE;
      cntNext   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lg        <= PORT_I;
      ownReg    <= PORT_I;
      sizeReg   <= '0;
      signedReg <= 1'b0;
      addrReg   <= '0;
      iRdataReg <= '0;
      dRdataReg <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (iGnt || dGnt) begin
        lg        <= dGnt;
        ownReg    <= dGnt;
        addrReg   <= dGnt ? bus.d_addr : bus.i_addr;
        sizeReg   <= bus.d_size;
        signedReg <= bus.d_signed;
      end
      if (lastCycle && (ownReg == PORT_I)) iRdataReg <= bus.mem_dout;
      if (lastCycle && (ownReg == PORT_D)) dRdataReg <= fmtData;
    end
  end

  // Response data bypasses the holding register on the rvalid cycle itself.
  always_comb begin
    bus.i_gnt    = iGnt;
    bus.d_gnt    = dGnt;
    bus.i_rvalid = lastCycle && (ownReg == PORT_I);
    bus.d_rvalid = lastCycle && (ownReg == PORT_D);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_dout : iRdataReg;
    bus.d_rdata  = bus.d_rvalid ? fmtData : dRdataReg;
    bus.mem_we   = storeGnt ? laneMask(bus.d_size) : '0;
    bus.mem_addr = (iGnt || dGnt) ? (dGnt ? bus.d_addr : bus.i_addr) : addrReg;
    bus.mem_din  = storeGnt ? bus.d_wdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: READ_LAT=1 and READ_LAT=3 instances behind a
// selector, directed table, corner sequences and a random run vs. a model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic iReq, dReq, dWe, dSigned;
  logic [1:0] dSize;
  logic [31:0] iAddr, dAddr, dWdata;
  logic doutForce;
  logic [31:0] forceVal;
  logic iGnt, dGnt, iRvalid, dRvalid;
  logic [31:0] iRdata, dRdata, memAddr, memDin;
  logic [3:0] memWe;
  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .READ_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(32), .READ_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] fmtModel(input logic [31:0] w, input logic [1:0] size,
                                           input logic sgn);
    int bits;
    logic [31:0] mask, v;
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    if (bits == 32) return w;
    mask = (32'd1 << bits) - 32'd1;
    v = w & mask;
    if (sgn && w[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] weModel(input logic [1:0] size);
    int bytes;
    bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    return 4'((1 << bytes) - 1);
  endfunction

  // RAM manager model: synchronous read returning the address seen READ_LAT edges earlier.
  logic [31:0] hist1;
  logic [31:0] hist3 [3];
  always @(posedge clk) begin
    hist1    <= bus1.mem_addr;
    hist3[0] <= bus3.mem_addr;
    hist3[1] <= hist3[0];
    hist3[2] <= hist3[1];
  end
  assign bus1.mem_dout = doutForce ? forceVal : memWord(hist1);
  assign bus3.mem_dout = doutForce ? forceVal : memWord(hist3[2]);

  assign bus1.i_req = !sel && iReq;
  assign bus3.i_req = sel && iReq;
  assign bus1.d_req = !sel && dReq;
  assign bus3.d_req = sel && dReq;
  assign bus1.i_addr = iAddr;   assign bus3.i_addr = iAddr;
  assign bus1.d_we = dWe;       assign bus3.d_we = dWe;
  assign bus1.d_size = dSize;   assign bus3.d_size = dSize;
  assign bus1.d_signed = dSigned; assign bus3.d_signed = dSigned;
  assign bus1.d_addr = dAddr;   assign bus3.d_addr = dAddr;
  assign bus1.d_wdata = dWdata; assign bus3.d_wdata = dWdata;

  assign iGnt    = sel ? bus3.i_gnt    : bus1.i_gnt;
  assign dGnt    = sel ? bus3.d_gnt    : bus1.d_gnt;
  assign iRvalid = sel ? bus3.i_rvalid : bus1.i_rvalid;
  assign dRvalid = sel ? bus3.d_rvalid : bus1.d_rvalid;
  assign iRdata  = sel ? bus3.i_rdata  : bus1.i_rdata;
  assign dRdata  = sel ? bus3.d_rdata  : bus1.d_rdata;
  assign memWe   = sel ? bus3.mem_we   : bus1.mem_we;
  assign memAddr = sel ? bus3.mem_addr : bus1.mem_addr;
  assign memDin  = sel ? bus3.mem_din  : bus1.mem_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s (lat=%0d) t=%0t actual=%h required=%h", nm, sel ? 3 : 1, $time, act, exp);
    end
  endtask

  task automatic chkAllZero(input string nm);
    chk({nm, "_i_gnt"}, iGnt, 0);       chk({nm, "_d_gnt"}, dGnt, 0);
    chk({nm, "_i_rvalid"}, iRvalid, 0); chk({nm, "_d_rvalid"}, dRvalid, 0);
    chk({nm, "_i_rdata"}, iRdata, 0);   chk({nm, "_d_rdata"}, dRdata, 0);
    chk({nm, "_mem_we"}, memWe, 0);     chk({nm, "_mem_addr"}, memAddr, 0);
    chk({nm, "_mem_din"}, memDin, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; iReq = 1'b0; dReq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runRandom(input int cycles);
    int lat;
    logic lgM, pv, pPort, pSgn, due, canG, eIG, eDG, prevIG, prevDG;
    logic [31:0] pAddr, lastI, lastD;
    logic [1:0] pSize;
    int pDue;
    lat = sel ? 3 : 1;
    lgM = 1'b0; pv = 1'b0; pPort = 1'b0; pSgn = 1'b0; pAddr = '0; pSize = '0; pDue = 0;
    lastI = '0; lastD = '0; prevIG = 1'b0; prevDG = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      if (prevIG) iReq = 1'b0;
      if (prevDG) dReq = 1'b0;
      if (!iReq && $urandom_range(99) < 60) begin
        iReq = 1'b1; iAddr = $urandom & 32'h0000FFFC;
      end
      if (!dReq && $urandom_range(99) < 60) begin
        dReq = 1'b1; dWe = 1'($urandom_range(1)); dSize = 2'($urandom_range(3));
        dSigned = 1'($urandom_range(1)); dAddr = $urandom & 32'h0000FFFF; dWdata = $urandom;
      end
      #1;
      due  = pv && (pDue == cyc);
      canG = !pv || due;
      eIG = 1'b0; eDG = 1'b0;
      if (canG) begin
        if (iReq && dReq) begin
          if (lgM) eIG = 1'b1; else eDG = 1'b1;
        end else begin
          eIG = iReq; eDG = dReq;
        end
      end
      if (due && !pPort) lastI = memWord(pAddr);
      if (due && pPort)  lastD = fmtModel(memWord(pAddr), pSize, pSgn);
      chk("rnd_i_gnt", iGnt, eIG);
      chk("rnd_d_gnt", dGnt, eDG);
      chk("rnd_i_rvalid", iRvalid, due && !pPort);
      chk("rnd_d_rvalid", dRvalid, due && pPort);
      chk("rnd_i_rdata", iRdata, lastI);
      chk("rnd_d_rdata", dRdata, lastD);
      chk("rnd_mem_we", memWe, (eDG && dWe) ? weModel(dSize) : 4'h0);
      if (eIG || eDG) chk("rnd_mem_addr", memAddr, eDG ? dAddr : iAddr);
      else if (pv)    chk("rnd_mem_addr_hold", memAddr, pAddr);
      if (eDG && dWe) chk("rnd_mem_din", memDin, dWdata);
      if (due) pv = 1'b0;
      if (eIG || eDG) lgM = eDG;
      if (eIG || (eDG && !dWe)) begin
        pv = 1'b1; pPort = eDG; pAddr = eDG ? dAddr : iAddr;
        pSize = dSize; pSgn = dSigned; pDue = cyc + lat;
      end
      prevIG = eIG; prevDG = eDG;
    end
    @(negedge clk);
    iReq = 1'b0; dReq = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [3:0]  expWe;
    logic [31:0] expRdata;
  } vecT;
  vecT vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    sz     sg    addr   wdata         dout          we     rdata
    vecs[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        4'hF, 32'h0};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h000000F0, 4'h0, 32'hFFFFFFF0};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000F0, 4'h0, 32'h000000F0};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h0,        4'h3, 32'h0};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h0000ABCD, 4'h0, 32'hFFFFABCD};
    vecs[5] = '{1'b1, 2'b00, 1'b1, 32'h31, 32'hCAFEF00D, 32'h0,        4'h1, 32'h0};
    vecs[6] = '{1'b0, 2'b10, 1'b1, 32'h40, 32'h0,        32'h80000001, 4'h0, 32'h80000001};
    vecs[7] = '{1'b0, 2'b11, 1'b1, 32'h44, 32'h0,        32'hF00080FF, 4'h0, 32'hF00080FF};
    vecs[8] = '{1'b0, 2'b01, 1'b0, 32'h46, 32'h0,        32'h12348001, 4'h0, 32'h00008001};

    rst_n = 1'b0; sel = 1'b0; doutForce = 1'b0; forceVal = '0;
    iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0; dSize = '0; dSigned = 1'b0;
    dAddr = '0; dWdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chkAllZero("reset1");
    sel = 1'b1; #1;
    chkAllZero("reset3");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports held: round-robin starting with D, one response per cycle.
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h100;
    dReq = 1'b1; dWe = 1'b0; dSize = 2'b10; dSigned = 1'b0; dAddr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("alt_d_gnt", dGnt, (k % 2) == 0);
      chk("alt_i_gnt", iGnt, (k % 2) == 1);
      if (k > 0) begin
        chk("alt_d_rvalid", dRvalid, ((k - 1) % 2) == 0);
        chk("alt_i_rvalid", iRvalid, ((k - 1) % 2) == 1);
        if ((k - 1) % 2 == 0) chk("alt_d_rdata", dRdata, memWord(32'h200));
        else                  chk("alt_i_rdata", iRdata, memWord(32'h100));
      end
    end
    doReset();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dReq = 1'b1; dWe = vecs[i].we; dSize = vecs[i].size; dSigned = vecs[i].sgn;
      dAddr = vecs[i].addr; dWdata = vecs[i].wdata;
      doutForce = 1'b1; forceVal = vecs[i].dout;
      #1;
      chk("tbl_d_gnt", dGnt, 1);
      chk("tbl_mem_we", memWe, vecs[i].expWe);
      chk("tbl_mem_addr", memAddr, vecs[i].addr);
      if (vecs[i].we) chk("tbl_mem_din", memDin, vecs[i].wdata);
      @(negedge clk);
      dReq = 1'b0;
      #1;
      chk("tbl_mem_we_next", memWe, 0);
      chk("tbl_d_rvalid", dRvalid, !vecs[i].we);
      if (!vecs[i].we) chk("tbl_d_rdata", dRdata, vecs[i].expRdata);
    end
    doutForce = 1'b0;

    // READ_LAT=3 fetch with a store queued behind it.
    sel = 1'b1;
    doReset();
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h40;
    #1;
    chk("l3_i_gnt", iGnt, 1);
    chk("l3_mem_addr_g", memAddr, 32'h40);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      iReq = 1'b0;
      if (k == 1) begin
        dReq = 1'b1; dWe = 1'b1; dSize = 2'b10; dAddr = 32'h80; dWdata = 32'h11223344;
      end
      #1;
      chk("l3_i_rvalid", iRvalid, k == 3);
      chk("l3_d_gnt", dGnt, k == 3);
      chk("l3_mem_we", memWe, (k == 3) ? 4'hF : 4'h0);
      if (k < 3) chk("l3_mem_addr_hold", memAddr, 32'h40);
      else begin
        chk("l3_i_rdata", iRdata, memWord(32'h40));
        chk("l3_mem_din", memDin, 32'h11223344);
      end
    end
    @(negedge clk);
    dReq = 1'b0;
    #1;
    chk("l3_mem_we_after", memWe, 0);
    chk("l3_i_rvalid_after", iRvalid, 0);

    // Reset lands while a READ_LAT=3 load is outstanding.
    doReset();
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dSize = 2'b00; dSigned = 1'b1; dAddr = 32'h13;
    #1;
    chk("rw_d_gnt", dGnt, 1);
    @(negedge clk);
    dReq = 1'b0; rst_n = 1'b0;
    #1;
    chkAllZero("rw_in_reset_a");
    @(negedge clk);
    #1;
    chkAllZero("rw_in_reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rw_no_rvalid", dRvalid, 0);
      chk("rw_d_rdata", dRdata, 0);
      @(negedge clk);
    end
    dReq = 1'b1; dWe = 1'b0; dSize = 2'b10; dSigned = 1'b0; dAddr = 32'h44;
    #1;
    chk("rw_regrant", dGnt, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      dReq = 1'b0;
      #1;
      chk("rw_d_rvalid", dRvalid, k == 3);
    end
    chk("rw_d_rdata_new", dRdata, memWord(32'h44));

    sel = 1'b0;
    doReset();
    runRandom(300);
    sel = 1'b1;
    doReset();
    runRandom(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
